fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 10 +
 rtl/fetch_unit.sv | 163 ++++++++++++++++
 tb/tb_fetch_unit.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between fetch_unit (master) and the memory (slave).
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_rvalid, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_rvalid, output imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit: IDLE/WAIT/HOLD/FLUSH sequencer feeding decode.
// Optional feature macro FETCH_MISALIGN_TRAP_EN: misaligned redirects present a trap NOP instead of fetching.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall_f,
    input  logic                redirect_valid,
    input  logic [31:0]         redirect_pc,
    fetch_unit_if.master        imem,
    output logic                valid_f,
    output logic [31:0]         inst_f,
    output logic [31:0]         pc_f,
    output logic [31:0]         pc_plus_4_f,
    output logic                misalign_f
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    state_t      state_r, state_s;
    logic [31:0] pc_r, pc_s;
    logic [31:0] inst_r, inst_s;
    logic [31:0] pcf_r, pcf_s;
    logic [31:0] pc4_r, pc4_s;
    logic        valid_r, valid_s;
    logic        mis_r, mis_s;
    logic        pend_r, pend_s;
    logic        req_s;
    logic [31:0] addr_s;
    logic [31:0] tgt_s;
    logic        misal_s;
    logic        outstanding_s;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign tgt_s   = redirect_pc;
    assign misal_s = (redirect_pc[1:0] != 2'b00);
`else
    assign tgt_s   = redirect_pc & 32'hFFFF_FFFC;
    assign misal_s = 1'b0;
`endif

    // A response is still owed after this cycle; pend_r covers a trap taken while one was in flight.
    assign outstanding_s = ((state_r == WAIT) || (state_r == FLUSH) || pend_r) && !imem.imem_rvalid;

    // Next-state, next-register and request decode; redirect beats every other event.
    always_comb begin
        state_s = state_r;
        pc_s    = pc_r;
        inst_s  = inst_r;
        pcf_s   = pcf_r;
        pc4_s   = pc4_r;
        valid_s = valid_r;
        mis_s   = mis_r;
        pend_s  = pend_r;
        req_s   = 1'b0;
        addr_s  = pc_r;
        if (redirect_valid) begin
            pc_s = tgt_s;
            if (misal_s) begin
                state_s = HOLD;
                valid_s = 1'b1;
                mis_s   = 1'b1;
                inst_s  = NOP_INST;
                pcf_s   = redirect_pc;
                pc4_s   = redirect_pc + 32'd4;
                pend_s  = outstanding_s;
            end else begin
                state_s = outstanding_s ? FLUSH : IDLE;
                valid_s = 1'b0;
                mis_s   = 1'b0;
                pend_s  = 1'b0;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    req_s   = 1'b1;
                    addr_s  = pc_r;
                    state_s = WAIT;
                end
                WAIT: begin
                    if (imem.imem_rvalid) begin
                        inst_s  = imem.imem_rdata;
                        pcf_s   = pc_r;
                        pc4_s   = pc_r + 32'd4;
                        valid_s = 1'b1;
                        mis_s   = 1'b0;
                        state_s = HOLD;
                    end else begin
                        state_s = WAIT;
                    end
                end
                HOLD: begin
                    if (stall_f) begin
                        pend_s = pend_r && !imem.imem_rvalid;
                    end else begin
                        valid_s = 1'b0;
                        mis_s   = 1'b0;
                        pc_s    = pc_r + 32'd4;
                        pend_s  = 1'b0;
                        // A trap left a response in flight: drain it before issuing the next request.
                        if (pend_r) begin
                            state_s = imem.imem_rvalid ? IDLE : FLUSH;
                        end else begin
                            req_s   = 1'b1;
                            addr_s  = pc_r + 32'd4;
                            state_s = WAIT;
                        end
                    end
                end
                FLUSH: begin
                    if (imem.imem_rvalid) begin
                        state_s = IDLE;
                    end else begin
                        state_s = FLUSH;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // State and presented-instruction registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            pc_r    <= RESET_PC;
            inst_r  <= 32'h0000_0000;
            pcf_r   <= 32'h0000_0000;
            pc4_r   <= 32'h0000_0000;
            valid_r <= 1'b0;
            mis_r   <= 1'b0;
            pend_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            inst_r  <= inst_s;
            pcf_r   <= pcf_s;
            pc4_r   <= pc4_s;
            valid_r <= valid_s;
            mis_r   <= mis_s;
            pend_r  <= pend_s;
        end
    end

    assign imem.imem_req  = req_s & ~reset;
    assign imem.imem_addr = addr_s;
    assign valid_f        = valid_r;
    assign inst_f         = inst_r;
    assign pc_f           = pcf_r;
    assign pc_plus_4_f    = pc4_r;
    assign misalign_f     = mis_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random traffic against a transaction-level model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall_f = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        valid_f, misalign_f;
    logic [31:0] inst_f, pc_f, pc_plus_4_f;

    fetch_unit_if imem_bus();

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall_f        (stall_f),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (imem_bus.master),
        .valid_f        (valid_f),
        .inst_f         (inst_f),
        .pc_f           (pc_f),
        .pc_plus_4_f    (pc_plus_4_f),
        .misalign_f     (misalign_f)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: next fetch address, whether a response is owed and wanted, and what decode sees.
    logic [31:0] m_pc, m_inst, m_ipc, m_ip4;
    bit          m_pend, m_want, m_valid, m_mis;

    // Memory: one response per request after mem_lat cycles.
    bit          mem_busy;
    int          mem_cd;
    int          mem_lat = 1;
    logic [31:0] mem_addr;

    logic [31:0] req_log[$];
    logic [31:0] pres_log[$];
    logic [31:0] pres4_log[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0200) return 32'h00A0_0093;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic clear_logs();
        req_log.delete();
        pres_log.delete();
        pres4_log.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        redirect_valid = 1'b0;
        stall_f = 1'b0;
        imem_bus.imem_rvalid = 1'b0;
        imem_bus.imem_rdata = 32'h0;
        #1;
        chk("reset_req", {31'd0, imem_bus.imem_req}, 32'd0);
        m_pc = 32'h0; m_inst = 32'h0; m_ipc = 32'h0; m_ip4 = 32'h0;
        m_pend = 1'b0; m_want = 1'b0; m_valid = 1'b0; m_mis = 1'b0;
        mem_busy = 1'b0;
        clear_logs();
    endtask

    task automatic cyc(input logic rd, input logic [31:0] rp, input logic st);
        logic        rv, exp_req, trap, consume;
        logic [31:0] rdat, exp_addr, tgt;
        @(negedge clk);
        reset = 1'b0;
        redirect_valid = rd;
        redirect_pc = rp;
        stall_f = st;
        rv = mem_busy && (mem_cd == 1);
        rdat = rv ? mem_word(mem_addr) : $urandom;
        imem_bus.imem_rvalid = rv;
        imem_bus.imem_rdata = rdat;
        #1;
        exp_req  = !rd && !m_pend && (!m_valid || !st);
        exp_addr = m_valid ? m_pc + 32'd4 : m_pc;
        chk("imem_req", {31'd0, imem_bus.imem_req}, {31'd0, exp_req});
        if (exp_req) chk("imem_addr", imem_bus.imem_addr, exp_addr);
        chk("valid_f", {31'd0, valid_f}, {31'd0, m_valid});
        chk("inst_f", inst_f, m_inst);
        chk("pc_f", pc_f, m_ipc);
        chk("pc_plus_4_f", pc_plus_4_f, m_ip4);
        chk("misalign_f", {31'd0, misalign_f}, {31'd0, m_mis});
        if (valid_f === 1'b1) begin
            pres_log.push_back(pc_f);
            pres4_log.push_back(pc_plus_4_f);
        end
        if (imem_bus.imem_req === 1'b1) req_log.push_back(imem_bus.imem_addr);
`ifdef FETCH_MISALIGN_TRAP_EN
        tgt = rp;
        trap = (rp[1:0] != 2'b00);
`else
        tgt = rp & 32'hFFFF_FFFC;
        trap = 1'b0;
`endif
        if (rd) begin
            if (rv) m_pend = 1'b0;
            m_want = 1'b0;
            m_pc = tgt;
            if (trap) begin
                m_valid = 1'b1; m_mis = 1'b1; m_inst = 32'h0000_0013;
                m_ipc = rp; m_ip4 = rp + 32'd4;
            end else begin
                m_valid = 1'b0; m_mis = 1'b0;
            end
        end else begin
            consume = m_valid && !st;
            if (rv && m_pend) begin
                m_pend = 1'b0;
                if (m_want) begin
                    m_valid = 1'b1; m_mis = 1'b0; m_inst = rdat;
                    m_ipc = m_pc; m_ip4 = m_pc + 32'd4;
                end
                m_want = 1'b0;
            end
            if (consume) begin
                m_valid = 1'b0; m_mis = 1'b0; m_pc = m_pc + 32'd4;
            end
            if (exp_req) begin
                m_pend = 1'b1; m_want = 1'b1;
            end
        end
        if (rv) mem_busy = 1'b0;
        else if (mem_busy) mem_cd--;
        if (imem_bus.imem_req === 1'b1) begin
            mem_busy = 1'b1;
            mem_cd = mem_lat;
            mem_addr = imem_bus.imem_addr;
        end
    endtask

    initial begin
        int n0;
        imem_bus.imem_rvalid = 1'b0;
        imem_bus.imem_rdata = 32'h0;

        // Sequential stream from reset, 1-cycle memory.
        do_reset();
        mem_lat = 1;
        for (int i = 0; i < 8; i++) cyc(1'b0, 32'h0, 1'b0);
        chk("seq_req0", req_log[0], 32'h0);
        chk("seq_req1", req_log[1], 32'h4);
        chk("seq_req2", req_log[2], 32'h8);
        chk("seq_pc0", pres_log[0], 32'h0);
        chk("seq_pc1", pres_log[1], 32'h4);
        chk("seq_pc2", pres_log[2], 32'h8);
        chk("seq_p4_0", pres4_log[0], 32'h4);
        chk("seq_p4_2", pres4_log[2], 32'hC);

        // Stall holds the presented instruction and blocks requests.
        do_reset();
        cyc(1'b1, 32'h200, 1'b0);
        cyc(1'b0, 32'h0, 1'b1);
        cyc(1'b0, 32'h0, 1'b1);
        n0 = req_log.size();
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 32'h0, 1'b1);
            chk("stall_inst", inst_f, 32'h00A0_0093);
            chk("stall_pc", pc_f, 32'h200);
        end
        chk("stall_noreq", req_log.size(), n0);
        cyc(1'b0, 32'h0, 1'b0);
        chk("stall_release", req_log[$], 32'h204);

        // Redirect while waiting on a slow response.
        do_reset();
        mem_lat = 3;
        cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b1, 32'h100, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b0, 32'h0, 1'b1);
        chk("flush_req", req_log[1], 32'h100);
        chk("flush_pres", pres_log[0], 32'h100);

        // Redirect coincident with the response.
        do_reset();
        mem_lat = 1;
        cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b1, 32'h300, 1'b0);
        cyc(1'b0, 32'h0, 1'b1);
        chk("coinc_req", req_log[1], 32'h300);
        for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 1'b1);
        chk("coinc_pres", pres_log[0], 32'h300);

        // PC wrap at the top of the address space.
        do_reset();
        cyc(1'b1, 32'hFFFF_FFFC, 1'b0);
        cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0);
        chk("wrap_p4", pc_plus_4_f, 32'h0);
        chk("wrap_req", req_log[$], 32'h0);

        // Misaligned redirect target.
        do_reset();
        cyc(1'b1, 32'h102, 1'b0);
        cyc(1'b0, 32'h0, 1'b1);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis_noreq", req_log.size(), 32'd0);
        chk("mis_flag", {31'd0, misalign_f}, 32'd1);
        chk("mis_inst", inst_f, 32'h0000_0013);
        chk("mis_pc", pc_f, 32'h102);
`else
        chk("mis_req", req_log[0], 32'h100);
        chk("mis_flag", {31'd0, misalign_f}, 32'd0);
`endif

        // Random traffic, including mid-operation resets.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic        rd, st;
            logic [31:0] rp;
            int          sel;
            if ($urandom_range(99) == 0) do_reset();
            mem_lat = $urandom_range(3, 1);
            rd = ($urandom_range(7) == 0);
            st = ($urandom_range(2) == 0);
            sel = $urandom_range(3);
            if (sel == 0) rp = 32'hFFFF_FFFC;
            else if (sel == 1) rp = $urandom;
            else rp = $urandom & 32'hFFFF_FFFC;
            cyc(rd, rp, st);
            if (req_log.size() > 64) clear_logs();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
